// File: rtl/counter_timer_arbiter_pkg.sv
// Shared types for the timer arbiter: FSM state encoding and the clock/reset control bundle.
package counter_timer_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    COUNT = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic Clock;
    logic Reset;
  } Data_Control_Control_T;

endpackage

// File: rtl/counter_timer_arbiter_counter.sv
// Modulo-MAX up counter with synchronous load (load beats enable); clock/reset come from the ctrl bundle.
module Counter_counter
  import counter_timer_arbiter_pkg::*;
#(
  parameter int MAX   = 12,
  parameter int WIDTH = $clog2(MAX)
) (
  input  Data_Control_Control_T i_ctrl,
  input  logic [WIDTH-1:0]      i_d,
  input  logic                  i_load,
  input  logic                  i_enable,
  output logic [WIDTH-1:0]      o_q
);

  logic             w_clk;
  logic             w_rst;
  logic [WIDTH-1:0] r_q;

  assign w_clk = i_ctrl.Clock;
  assign w_rst = i_ctrl.Reset;
  assign o_q   = r_q;

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_d;
    end else if (i_enable) begin
      r_q <= (r_q == WIDTH'(MAX - 1)) ? '0 : r_q + WIDTH'(1);
    end
  end

endmodule

// File: rtl/counter_timer_arbiter.sv
// Round-robin arbiter sharing one interval counter among NREQ requesters.
// Grant lasts LOAD + len + DONE cycles; dropping the owner's req aborts without a done pulse.
module counter_timer_arbiter
  import counter_timer_arbiter_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int MAX   = 12,
  parameter int WIDTH = $clog2(MAX)
) (
  input  Data_Control_Control_T  i_ctrl,
  input  logic [NREQ-1:0]        i_req,
  input  logic [NREQ*WIDTH-1:0]  i_len,
  output logic [NREQ-1:0]        o_grant,
  output logic [NREQ-1:0]        o_done,
  output logic                   o_busy,
  output logic [WIDTH-1:0]       o_elapsed
);

  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [WIDTH-1:0] LMAX = WIDTH'(MAX - 1);

  logic             w_clk;
  logic             w_rst;
  state_t           r_state;
  logic [IDXW-1:0]  r_idx;
  logic [IDXW-1:0]  r_ptr;
  logic [WIDTH-1:0] r_len;
  logic [NREQ-1:0]  r_grant;
  logic [NREQ-1:0]  r_done;
  logic [IDXW-1:0]  w_pick;
  logic [IDXW-1:0]  w_next;
  logic [WIDTH-1:0] w_len_sel;
  logic [WIDTH-1:0] w_len_clamp;
  logic             w_own_req;
  logic             w_load;
  logic             w_enable;
  logic [WIDTH-1:0] w_q;

  // First requester at or after ptr, searching cyclically.
  function automatic logic [IDXW-1:0] rr_pick(input logic [NREQ-1:0] req,
                                              input logic [IDXW-1:0] ptr);
    logic [IDXW-1:0] pick;
    int              j;
    pick = ptr;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % NREQ;
      if (req[j]) pick = IDXW'(j);
    end
    return pick;
  endfunction

  assign w_clk       = i_ctrl.Clock;
  assign w_rst       = i_ctrl.Reset;
  assign w_pick      = rr_pick(i_req, r_ptr);
  assign w_len_sel   = i_len[w_pick*WIDTH +: WIDTH];
  assign w_len_clamp = (w_len_sel > LMAX) ? LMAX : w_len_sel;
  assign w_next      = (r_idx == IDXW'(NREQ - 1)) ? '0 : r_idx + IDXW'(1);
  assign w_own_req   = i_req[r_idx];
  assign w_load      = (r_state == LOAD);
  // Gating with the owner's req keeps q frozen on the aborting edge.
  assign w_enable    = (r_state == COUNT) && w_own_req;

  Counter_counter #(
    .MAX   (MAX),
    .WIDTH (WIDTH)
  ) u_counter (
    .i_ctrl   (i_ctrl),
    .i_d      ('0),
    .i_load   (w_load),
    .i_enable (w_enable),
    .o_q      (w_q)
  );

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_ptr   <= '0;
      r_len   <= '0;
      r_grant <= '0;
      r_done  <= '0;
    end else begin
      r_done <= '0;
      case (r_state)
        IDLE: begin
          if (|i_req) begin
            r_idx   <= w_pick;
            r_len   <= w_len_clamp;
            r_grant <= {{(NREQ-1){1'b0}}, 1'b1} << w_pick;
            r_state <= LOAD;
          end
        end
        LOAD: begin
          if (!w_own_req) begin
            r_grant <= '0;
            r_ptr   <= w_next;
            r_state <= IDLE;
          end else if (r_len == '0) begin
            r_done  <= r_grant;
            r_state <= DONE;
          end else begin
            r_state <= COUNT;
          end
        end
        COUNT: begin
          if (!w_own_req) begin
            r_grant <= '0;
            r_ptr   <= w_next;
            r_state <= IDLE;
          end else if (w_q == r_len - WIDTH'(1)) begin
            r_done  <= r_grant;
            r_state <= DONE;
          end
        end
        DONE: begin
          r_grant <= '0;
          r_ptr   <= w_next;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_grant   = r_grant;
  assign o_done    = r_done;
  assign o_busy    = (r_state != IDLE);
  assign o_elapsed = (r_state == IDLE) ? '0 : w_q;

endmodule

// File: tb/tb_counter_timer_arbiter.sv
// Scoreboard bench: a grant-timeline reference model predicts each cycle's outputs; a monitor checks them.
module tb_counter_timer_arbiter;
  import counter_timer_arbiter_pkg::*;

  localparam int NREQ  = 4;
  localparam int MAX   = 12;
  localparam int WIDTH = 4;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  Data_Control_Control_T ctrl;
  logic [NREQ-1:0]       req = '0;
  logic [NREQ*WIDTH-1:0] len = '0;
  logic [NREQ-1:0]       o_grant;
  logic [NREQ-1:0]       o_done;
  logic                  o_busy;
  logic [WIDTH-1:0]      o_elapsed;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  assign ctrl = {clk, rst};

  counter_timer_arbiter #(
    .NREQ  (NREQ),
    .MAX   (MAX),
    .WIDTH (WIDTH)
  ) dut (
    .i_ctrl    (ctrl),
    .i_req     (req),
    .i_len     (len),
    .o_grant   (o_grant),
    .o_done    (o_done),
    .o_busy    (o_busy),
    .o_elapsed (o_elapsed)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NREQ-1:0]  grant;
    logic [NREQ-1:0]  done;
    logic             busy;
    logic [WIDTH-1:0] el;
    bit               chk_el;
  } exp_t;

  exp_t sbq[$];

  // Reference: an owner holds the timer for t = 0 .. L+1 cycles after its grant rises;
  // t=0 is the load cycle, elapsed reads t-1 afterwards, done fires at t=L+1.
  int m_owner = -1;
  int m_t     = 0;
  int m_L     = 0;
  int m_ptr   = 0;

  always @(posedge clk) begin
    exp_t e;
    int   cand;
    cyc++;
    if (rst) begin
      m_owner = -1;
      m_ptr   = 0;
    end else if (m_owner < 0) begin
      for (int k = NREQ - 1; k >= 0; k--) begin
        cand = (m_ptr + k) % NREQ;
        if (req[cand]) m_owner = cand;
      end
      if (m_owner >= 0) begin
        m_L = int'(len[m_owner*WIDTH +: WIDTH]);
        if (m_L > MAX - 1) m_L = MAX - 1;
        m_t = 0;
      end
    end else if (m_t == m_L + 1 || !req[m_owner]) begin
      m_ptr   = (m_owner + 1) % NREQ;
      m_owner = -1;
    end else begin
      m_t++;
    end
    if (m_owner >= 0) begin
      e.grant  = NREQ'(1) << m_owner;
      e.done   = (m_t == m_L + 1) ? e.grant : '0;
      e.busy   = 1'b1;
      e.el     = (m_t > 0) ? WIDTH'(m_t - 1) : '0;
      e.chk_el = (m_t > 0);
    end else begin
      e.grant  = '0;
      e.done   = '0;
      e.busy   = 1'b0;
      e.el     = '0;
      e.chk_el = 1'b1;
    end
    sbq.push_back(e);
  end

  initial begin
    exp_t e;
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_empty cyc=%0d actual=no_expectation required=one_per_cycle", cyc);
      end else begin
        e = sbq.pop_front();
        checks++;
        if (o_grant !== e.grant) begin
          errors++;
          $display("FAIL grant cyc=%0d actual=%b required=%b", cyc, o_grant, e.grant);
        end
        checks++;
        if (o_done !== e.done) begin
          errors++;
          $display("FAIL done cyc=%0d actual=%b required=%b", cyc, o_done, e.done);
        end
        checks++;
        if (o_busy !== e.busy) begin
          errors++;
          $display("FAIL busy cyc=%0d actual=%b required=%b", cyc, o_busy, e.busy);
        end
        if (e.chk_el) begin
          checks++;
          if (o_elapsed !== e.el) begin
            errors++;
            $display("FAIL elapsed cyc=%0d actual=%0d required=%0d", cyc, o_elapsed, e.el);
          end
        end
      end
    end
  end

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_len(input int i, input int v);
    len[i*WIDTH +: WIDTH] = WIDTH'(v);
  endtask

  task automatic wait_owner_el(input logic [NREQ-1:0] g, input logic [WIDTH-1:0] v);
    int n = 0;
    while (!(o_grant === g && o_elapsed === v) && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 40) begin
      errors++;
      $display("FAIL wait_timeout cyc=%0d actual=grant %b elapsed %0d required=grant %b elapsed %0d",
               cyc, o_grant, o_elapsed, g, v);
    end
  endtask

  initial begin
    // Reset held two edges with every requester asking.
    req = 4'b1111;
    for (int i = 0; i < NREQ; i++) set_len(i, 2);
    rst = 1'b1;
    run(2);
    rst = 1'b0;
    run(20);
    req = '0;
    run(3);

    // Single request on requester 2, len 5.
    set_len(2, 5);
    req = 4'b0100;
    run(9);
    req = '0;
    run(3);

    // Round-robin among 0,1,3 with len 1.
    for (int i = 0; i < NREQ; i++) set_len(i, 1);
    req = 4'b1011;
    run(20);
    req = '0;
    run(3);

    // len 0 then an over-range len that must clamp.
    set_len(0, 0);
    req = 4'b0001;
    run(4);
    req = '0;
    run(2);
    set_len(3, 15);
    req = 4'b1000;
    run(16);
    req = '0;
    run(3);

    // Abort owner 1 at elapsed 3 while 2 waits.
    set_len(1, 8);
    set_len(2, 2);
    req = 4'b0110;
    wait_owner_el(4'b0010, 4'd3);
    req[1] = 1'b0;
    run(10);
    req = '0;
    run(3);

    // Reset in the middle of counting.
    set_len(2, 10);
    req = 4'b0100;
    wait_owner_el(4'b0100, 4'd4);
    rst = 1'b1;
    req = 4'b0101;
    run(1);
    rst = 1'b0;
    run(12);
    req = '0;
    run(3);

    // Randomized traffic with aborts and occasional resets.
    for (int c = 0; c < 2500; c++) begin
      if ($urandom_range(0, 5) == 0) req[$urandom_range(0, NREQ - 1)] ^= 1'b1;
      if ($urandom_range(0, 3) == 0) set_len($urandom_range(0, NREQ - 1), $urandom_range(0, 15));
      rst = ($urandom_range(0, 399) == 0);
      run(1);
    end
    rst = 1'b0;
    req = '0;
    run(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/counter_timer_arbiter.md
Name: counter_timer_arbiter

Overview:
- Shares one Counter_counter instance, used as an interval timer, among NREQ requesters.
- Each requester asks for a delay of len cycles. Grants are issued round-robin.
- The block sequences load/enable on the counter, holds the grant for the interval, and pulses done to the winner.
- Sits beside pipeline-stall and multi-cycle-unit logic that needs bounded wait timers without one counter per client.

Parameters:
- NREQ, 4, number of requesters (2..8).
- MAX, 12, counter modulus passed to Counter_counter; q ranges 0..MAX-1.
- WIDTH, $clog2(MAX), width of len and of the counter value.

Ports:
- ctrl  input  Data_Control_Control_T  control bundle; its Clock field is the single clock, its Reset field is the synchronous active-high reset.
- req  input  NREQ  per-requester request level; held until done or dropped to abort.
- len  input  NREQ x WIDTH  requested interval per requester; sampled at grant.
- grant  output  NREQ  one-hot; current owner of the timer.
- done  output  NREQ  one-cycle pulse to owner at interval end.
- busy  output  1  high whenever state != IDLE.
- elapsed  output  WIDTH  live counter q (0 when idle).

Behaviour:
- Reset (Reset=1 at a rising edge):
  - state=IDLE; grant=0, done=0, busy=0; round-robin pointer ptr=0.
  - The counter is reset through the shared ctrl bundle, so elapsed=0.
  - Reset takes effect mid-operation with no done pulse.
- Counter contract: load=1 loads d into q at the next edge (load beats enable); enable=1 increments q; otherwise q holds. This block drives d=0 permanently.
- IDLE:
  - If any req is high, select the first requester at or after ptr (cyclic) and latch idx and len_l = min(len[idx], MAX-1).
  - grant[idx] rises at the next edge. Next state is LOAD.
  - With no requests, stay in IDLE.
- LOAD (1 cycle):
  - Drive load=1, so q becomes 0.
  - Next state is DONE if len_l==0, else COUNT.
- COUNT:
  - Drive enable=1.
  - When q==len_l-1, go to DONE; q==len_l on entry to DONE. COUNT lasts exactly len_l cycles.
- DONE (1 cycle):
  - done[idx]=1, grant held, enable=0.
  - ptr = (idx+1) mod NREQ. Next state is IDLE and grant drops.
- Grant duration: exactly len_l+2 cycles (LOAD + len_l + DONE). From req sampled in IDLE to done high is len_l+2 cycles.
- Abort: if req[idx] is low at an edge in LOAD or COUNT, go to IDLE next cycle.
  - grant=0, no done pulse, ptr=(idx+1) mod NREQ, counter holds (not reloaded until the next grant).
- Requests from non-owners are ignored while busy and are never lost; level-sensitive re-evaluation happens in IDLE.
- Back-to-back: IDLE always intervenes, so there is a minimum 1 idle cycle between grants. Fairness: a continuously requesting client waits at most NREQ-1 full grants.
- len changes after grant are ignored (latched).
- Clamp: len values >= MAX are treated as MAX-1, so the counter never wraps.
- Outputs grant, done and busy are registered or decoded from registered state only; no combinational path from req to grant.

Decomposition:
- Shared package (Data/Control style header):
  - state enum {IDLE, LOAD, COUNT, DONE}, 2 bits.
  - helper macro for the one-hot round-robin pick.
- Reuse the existing Control bundle macros for Clock/Reset access.
- One sub-module: Counter_counter (existing), instantiated with MAX, d tied to 0, load/enable driven by the FSM, ctrl passed through.
- The round-robin picker stays inline (small combinational function).

Test Plan:
- Reset: hold Reset 2 cycles with req=4'b1111 → grant=0, done=0, busy=0, elapsed=0. After release, the first grant is grant=4'b0001.
- Single request: req[2]=1, len[2]=5 → grant=4'b0100 for 7 cycles; elapsed goes 0,1,2,3,4,5; done[2] pulses on the 7th grant cycle; next cycle grant=0.
- Round-robin: req=4'b1011 held, all len=1 → grant order 0,1,3,0,… Each grant lasts 3 cycles, separated by 1 idle cycle; done pulses in the same order.
- Boundaries:
  - len=0 → grant 2 cycles, done in the 2nd.
  - len=15 (MAX=12) → clamped to 11, grant 13 cycles, elapsed peaks at 11, no wrap.
- Abort: req[1]=1, len=8; drop req[1] when elapsed=3 → next cycle grant=0, no done; ptr advances so a pending req[2] is granted next.
- Reset mid-COUNT (elapsed=4): Reset=1 for one edge → IDLE, grant=0, elapsed=0, no done; arbitration restarts at requester 0.
